// File: rtl/aib_wb_adapt_mode_ctrl.sv
// Run-time FIFO-selection change sequencer for the AIB Wishbone adapter.
// Gates new strobes, drains in-flight transfers, pulses adapter reset, settles, then acks.
module aib_wb_adapt_mode_ctrl #(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DrainTimeout   = 64,
  parameter int unsigned RstHoldCycles  = 4,
  parameter int unsigned SettleCycles   = 4,
  parameter logic [1:0]  ResetFifoSel   = 2'd0
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_cfg_req,
  input  logic [1:0] i_cfg_fifo_sel,
  output logic       o_cfg_busy,
  output logic       o_cfg_ack,
  output logic       o_cfg_err,
  input  logic       i_m_wb_stb,
  output logic       o_m_wb_stall,
  output logic       o_a_wb_stb,
  input  logic       i_a_wb_stall,
  input  logic       i_a_wb_ack,
  output logic [1:0] o_fifo_sel,
  output logic       o_adapt_rst_n
);

  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned TmrMax0 = (DrainTimeout > RstHoldCycles) ? DrainTimeout : RstHoldCycles;
  localparam int unsigned TmrMax  = (TmrMax0 > SettleCycles) ? TmrMax0 : SettleCycles;
  localparam int unsigned TmrW    = $clog2(TmrMax + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_RESET  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [TmrW-1:0]   timer_r;
  logic [CntW-1:0]   outstanding_r;
  logic [1:0]        sel_r;
  logic [1:0]        fifo_sel_r;
  logic              adapt_rst_n_r;
  logic              gate_r;
  logic              err_r;
  logic              ack_r;
  logic              cerr_r;
  logic              busy_r;
  logic              drain_err_s;
  logic              enter_reset_s;
  logic              gate_nx_s;
  logic              inc_s;
  logic              dec_s;

  assign o_a_wb_stb    = i_m_wb_stb & ~gate_r;
  assign o_m_wb_stall  = i_a_wb_stall | gate_r;
  assign inc_s         = o_a_wb_stb & ~i_a_wb_stall;
  assign dec_s         = i_a_wb_ack;
  assign o_fifo_sel    = fifo_sel_r;
  assign o_adapt_rst_n = adapt_rst_n_r;
  assign o_cfg_ack     = ack_r;
  assign o_cfg_err     = cerr_r;
  assign o_cfg_busy    = busy_r;

  // Next-state decode; drain_err_s flags a timeout-forced exit from DRAIN.
  always_comb begin
    state_nx_s  = state_r;
    drain_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_cfg_req) begin
          state_nx_s = (i_cfg_fifo_sel != fifo_sel_r) ? ST_DRAIN : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == {CntW{1'b0}}) begin
          state_nx_s = ST_RESET;
        end else if (timer_r == TmrW'(DrainTimeout - 1)) begin
          state_nx_s  = ST_RESET;
          drain_err_s = 1'b1;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_RESET: begin
        if (timer_r == TmrW'(RstHoldCycles - 1)) begin
          state_nx_s = ST_SETTLE;
        end else begin
          state_nx_s = ST_RESET;
        end
      end
      ST_SETTLE: begin
        if (timer_r == TmrW'(SettleCycles - 1)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SETTLE;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
    enter_reset_s = (state_r == ST_DRAIN) && (state_nx_s == ST_RESET);
    // A no-change request goes straight to DONE without ever gating the master.
    gate_nx_s = (state_nx_s != ST_IDLE) && !((state_r == ST_IDLE) && (state_nx_s == ST_DONE));
  end

  // State, timer and registered outputs.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TmrW{1'b0}};
      sel_r         <= ResetFifoSel;
      fifo_sel_r    <= ResetFifoSel;
      adapt_rst_n_r <= 1'b0;
      gate_r        <= 1'b0;
      err_r         <= 1'b0;
      ack_r         <= 1'b0;
      cerr_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if ((state_nx_s != state_r) || (state_r == ST_IDLE)) begin
        timer_r <= {TmrW{1'b0}};
      end else begin
        timer_r <= timer_r + TmrW'(1);
      end
      if ((state_r == ST_IDLE) && i_cfg_req) begin
        sel_r <= i_cfg_fifo_sel;
      end
      if (enter_reset_s) begin
        fifo_sel_r <= sel_r;
      end
      if (state_r == ST_IDLE) begin
        err_r <= 1'b0;
      end else if (enter_reset_s) begin
        err_r <= drain_err_s;
      end
      adapt_rst_n_r <= (state_nx_s != ST_RESET);
      gate_r        <= gate_nx_s;
      busy_r        <= (state_nx_s != ST_IDLE);
      ack_r         <= (state_nx_s == ST_DONE);
      cerr_r        <= (state_nx_s == ST_DONE) && (state_r == ST_SETTLE) && err_r;
    end
  end

  // In-flight transaction counter: saturating, no underflow, cleared when the adapter is reset.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      outstanding_r <= {CntW{1'b0}};
    end else if (enter_reset_s) begin
      outstanding_r <= {CntW{1'b0}};
    end else if (inc_s && !dec_s && (outstanding_r != CntW'(MaxOutstanding))) begin
      outstanding_r <= outstanding_r + CntW'(1);
    end else if (dec_s && !inc_s && (outstanding_r != {CntW{1'b0}})) begin
      outstanding_r <= outstanding_r - CntW'(1);
    end
  end

endmodule

// File: tb/tb_aib_wb_adapt_mode_ctrl.sv
// Directed bench for aib_wb_adapt_mode_ctrl: a schedule-based reference model checked
// every cycle, plus hand-computed literal expectations at the key edges of each scenario.
module tb_aib_wb_adapt_mode_ctrl;
  localparam int MAXO = 4;
  localparam int DT   = 64;
  localparam int RH   = 4;
  localparam int SC   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_req;
  logic [1:0] cfg_sel;
  logic       m_stb;
  logic       a_stall;
  logic       a_ack;
  logic       cfg_busy;
  logic       cfg_ack;
  logic       cfg_err;
  logic       m_stall;
  logic       a_stb;
  logic [1:0] fifo_sel;
  logic       adapt_rst_n;

  always #5 clk = ~clk;

  aib_wb_adapt_mode_ctrl dut (
    .i_sys_clk      (clk),
    .i_rst_n        (rst_n),
    .i_cfg_req      (cfg_req),
    .i_cfg_fifo_sel (cfg_sel),
    .o_cfg_busy     (cfg_busy),
    .o_cfg_ack      (cfg_ack),
    .o_cfg_err      (cfg_err),
    .i_m_wb_stb     (m_stb),
    .o_m_wb_stall   (m_stall),
    .o_a_wb_stb     (a_stb),
    .i_a_wb_stall   (a_stall),
    .i_a_wb_ack     (a_ack),
    .o_fifo_sel     (fifo_sel),
    .o_adapt_rst_n  (adapt_rst_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: modes idle/drain/scheduled; once the drain ends the reset
  // window and ack edge are fixed arithmetically from the drain-end edge.
  int         n = 0;
  bit         started = 1'b0;
  int         m_mode = 0;
  int         m_cnt = 0;
  int         drain_start = 0;
  int         rst_start = -1000;
  int         ack_edge = -1000;
  bit         m_gate = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_err = 1'b0;
  bit         m_ack = 1'b0;
  bit         m_errout = 1'b0;
  bit         m_arst = 1'b0;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_pend = 2'd0;

  always @(posedge clk) begin
    bit inc;
    bit dec;
    bit fin;
    int cnt_old;
    n++;
    started = 1'b1;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_gate = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      m_sel = 2'd0; rst_start = -1000; ack_edge = -1000;
      m_arst = 1'b0; m_ack = 1'b0; m_errout = 1'b0;
    end else begin
      cnt_old = m_cnt;
      inc = m_stb && !m_gate && !a_stall;
      dec = a_ack;
      if (inc && !dec && m_cnt < MAXO) m_cnt++;
      else if (dec && !inc && m_cnt > 0) m_cnt--;
      if (m_mode == 0) begin
        if (cfg_req) begin
          m_busy = 1'b1;
          if (cfg_sel != m_sel) begin
            m_mode = 1; m_pend = cfg_sel; drain_start = n; m_gate = 1'b1;
          end else begin
            m_mode = 2; ack_edge = n; m_err = 1'b0;
          end
        end
      end else if (m_mode == 1) begin
        fin = (cnt_old == 0) || ((n - drain_start - 1) == DT - 1);
        if (fin) begin
          m_err = (cnt_old != 0);
          rst_start = n;
          ack_edge = n + RH + SC;
          m_sel = m_pend;
          m_cnt = 0;
          m_mode = 2;
        end
      end else begin
        if (n == ack_edge + 1) begin
          m_mode = 0; m_gate = 1'b0; m_busy = 1'b0;
          rst_start = -1000; ack_edge = -1000;
        end
      end
      m_arst = !(n >= rst_start && n < rst_start + RH);
      m_ack = (n == ack_edge);
      m_errout = m_ack && m_err;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk_b("busy", cfg_busy, m_busy);
      chk_b("ack", cfg_ack, m_ack);
      chk_b("err", cfg_err, m_errout);
      chk_v("fifo_sel", int'(fifo_sel), int'(m_sel));
      chk_b("adapt_rst_n", adapt_rst_n, m_arst);
      chk_b("m_stall", m_stall, a_stall | m_gate);
      chk_b("a_stb", a_stb, m_stb & !m_gate);
      chk_v("outstanding", int'(dut.outstanding_r), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cfg_req = 1'b0; cfg_sel = 2'd0;
    m_stb = 1'b0; a_stall = 1'b0; a_ack = 1'b0;

    // Reset state
    tick();
    chk_v("rst fifo_sel", int'(fifo_sel), 0);
    chk_b("rst adapt_rst_n", adapt_rst_n, 1'b0);
    chk_b("rst busy", cfg_busy, 1'b0);
    a_stall = 1'b1; #1;
    chk_b("rst stall follows adapter", m_stall, 1'b1);
    a_stall = 1'b0; #1;
    chk_b("rst stall released", m_stall, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_b("adapt_rst_n after release", adapt_rst_n, 1'b1);
    tick();

    // Idle switch 0 -> 3, nothing outstanding
    cfg_req = 1'b1; cfg_sel = 2'd3;
    tick();
    cfg_req = 1'b0;
    chk_b("sw E0 busy", cfg_busy, 1'b1);
    chk_b("sw E0 stall", m_stall, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        chk_b("sw E1 adapt_rst_n", adapt_rst_n, 1'b0);
        chk_v("sw E1 fifo_sel", int'(fifo_sel), 3);
      end
      if (k == 4) chk_b("sw E4 adapt_rst_n", adapt_rst_n, 1'b0);
      if (k == 5) chk_b("sw E5 adapt_rst_n", adapt_rst_n, 1'b1);
      if (k == 8) chk_b("sw E8 ack", cfg_ack, 1'b0);
      if (k == 9) begin
        chk_b("sw E9 ack", cfg_ack, 1'b1);
        chk_b("sw E9 err", cfg_err, 1'b0);
        chk_b("sw E9 stall", m_stall, 1'b1);
      end
      if (k == 10) chk_b("sw E10 busy", cfg_busy, 1'b0);
    end

    // Switch 3 -> 1 with three outstanding, acks at +10, +12, +15
    m_stb = 1'b1;
    tick(); tick();
    cfg_req = 1'b1; cfg_sel = 2'd1;
    tick();
    cfg_req = 1'b0;
    chk_v("drain start count", int'(dut.outstanding_r), 3);
    chk_b("drain a_stb gated", a_stb, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      a_ack = (k == 10 || k == 12 || k == 15 || k == 27);
      tick();
      if (k == 10) chk_v("drain cnt after ack1", int'(dut.outstanding_r), 2);
      if (k == 12) chk_v("drain cnt after ack2", int'(dut.outstanding_r), 1);
      if (k == 15) begin
        chk_v("drain cnt after ack3", int'(dut.outstanding_r), 0);
        chk_b("drain E15 adapt_rst_n", adapt_rst_n, 1'b1);
        chk_b("drain E15 a_stb gated", a_stb, 1'b0);
      end
      if (k == 16) begin
        chk_b("drain E16 adapt_rst_n", adapt_rst_n, 1'b0);
        chk_v("drain E16 fifo_sel", int'(fifo_sel), 1);
      end
      if (k == 20) chk_b("drain E20 adapt_rst_n", adapt_rst_n, 1'b1);
      if (k == 24) begin
        chk_b("drain E24 ack", cfg_ack, 1'b1);
        chk_b("drain E24 err", cfg_err, 1'b0);
      end
      if (k == 25) begin
        chk_b("held strobe passes", a_stb, 1'b1);
        m_stb = 1'b0;
      end
    end
    a_ack = 1'b0;

    // Outstanding counter: simultaneous, stalled, saturating, underflow
    m_stb = 1'b1;
    tick(); tick();
    chk_v("cnt two accepts", int'(dut.outstanding_r), 2);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk_v("cnt accept+ack", int'(dut.outstanding_r), 2);
    a_stall = 1'b1;
    tick();
    a_stall = 1'b0;
    chk_v("cnt stalled", int'(dut.outstanding_r), 2);
    tick(); tick(); tick();
    chk_v("cnt saturated", int'(dut.outstanding_r), 4);
    m_stb = 1'b0; a_ack = 1'b1;
    tick(); tick(); tick(); tick();
    chk_v("cnt drained", int'(dut.outstanding_r), 0);
    tick();
    chk_v("cnt spurious ack", int'(dut.outstanding_r), 0);
    a_ack = 1'b0;
    tick();

    // Drain timeout: switch 1 -> 2 with one transfer that never completes
    m_stb = 1'b1; cfg_req = 1'b1; cfg_sel = 2'd2;
    tick();
    m_stb = 1'b0; cfg_req = 1'b0;
    for (int k = 1; k <= 73; k++) begin
      tick();
      if (k == 63) begin
        chk_v("to E63 cnt", int'(dut.outstanding_r), 1);
        chk_b("to E63 adapt_rst_n", adapt_rst_n, 1'b1);
      end
      if (k == 64) begin
        chk_v("to E64 cnt cleared", int'(dut.outstanding_r), 0);
        chk_b("to E64 adapt_rst_n", adapt_rst_n, 1'b0);
        chk_v("to E64 fifo_sel", int'(fifo_sel), 2);
      end
      if (k == 68) chk_b("to E68 adapt_rst_n", adapt_rst_n, 1'b1);
      if (k == 71) chk_b("to E71 ack", cfg_ack, 1'b0);
      if (k == 72) begin
        chk_b("to E72 ack", cfg_ack, 1'b1);
        chk_b("to E72 err", cfg_err, 1'b1);
      end
      if (k == 73) chk_b("to E73 busy", cfg_busy, 1'b0);
    end

    // Same selection 2 -> 2 with a level request held over three edges
    cfg_req = 1'b1; cfg_sel = 2'd2;
    tick();
    chk_b("same E0 ack", cfg_ack, 1'b1);
    chk_b("same E0 err", cfg_err, 1'b0);
    chk_b("same E0 adapt_rst_n", adapt_rst_n, 1'b1);
    tick();
    chk_b("same E1 ack", cfg_ack, 1'b0);
    chk_b("same E1 busy", cfg_busy, 1'b0);
    tick();
    chk_b("same E2 re-ack", cfg_ack, 1'b1);
    cfg_req = 1'b0;
    tick();
    chk_b("same E3 ack", cfg_ack, 1'b0);

    // Reset while the adapter is held in reset: request abandoned
    cfg_req = 1'b1; cfg_sel = 2'd1;
    tick();
    cfg_req = 1'b0;
    tick();
    chk_v("mid E1 fifo_sel", int'(fifo_sel), 1);
    chk_b("mid E1 adapt_rst_n", adapt_rst_n, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk_v("mid rst fifo_sel", int'(fifo_sel), 0);
    chk_b("mid rst adapt_rst_n", adapt_rst_n, 1'b0);
    chk_b("mid rst busy", cfg_busy, 1'b0);
    chk_b("mid rst ack", cfg_ack, 1'b0);
    a_stall = 1'b1; #1;
    chk_b("mid rst stall", m_stall, 1'b1);
    a_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_b("mid release adapt_rst_n", adapt_rst_n, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_b("mid no ack", cfg_ack, 1'b0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aib_wb_adapt_mode_ctrl.md
Name: aib_wb_adapt_mode_ctrl

Overview:
- Sequences safe run-time changes of the AIB Wishbone adapter FIFO selection (`c_fifo_sel`: async/sync × SDR/DDR).
- Sits between the Wishbone master and the adapter, on the adapter's system clock.
- On a config request it blocks new Wishbone strobes and drains in-flight transactions (bounded by a timeout). It then holds the adapter in reset while switching the selection, waits for the adapter to settle, and acknowledges the request.

Parameters:
- MaxOutstanding, 4: max tracked in-flight Wishbone transactions. Counter width is $clog2(MaxOutstanding+1).
- DrainTimeout, 64: cycles allowed in DRAIN before forced switch.
- RstHoldCycles, 4: cycles `o_adapt_rst_n` is held low (≥1).
- SettleCycles, 4: cycles after reset release before ack (≥1; covers the adapter's internal reset synchroniser).
- ResetFifoSel, 2'd0: `o_fifo_sel` value after reset.

Ports:
- i_sys_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_cfg_req  in  1  level/pulse request to switch selection; sampled only in IDLE.
- i_cfg_fifo_sel  in  2  requested selection; sampled with i_cfg_req.
- o_cfg_busy  out  1  high whenever state ≠ IDLE.
- o_cfg_ack  out  1  one-cycle pulse when a request completes.
- o_cfg_err  out  1  valid with o_cfg_ack; 1 = drain timed out and transactions were discarded.
- i_m_wb_stb  in  1  master strobe.
- o_m_wb_stall  out  1  stall to master = i_a_wb_stall | gate.
- o_a_wb_stb  out  1  strobe to adapter = i_m_wb_stb & ~gate.
- i_a_wb_stall  in  1  adapter stall.
- i_a_wb_ack  in  1  adapter ack (also forwarded to the master by the top level).
- o_fifo_sel  out  2  drives adapter `c_fifo_sel`; registered.
- o_adapt_rst_n  out  1  adapter reset; registered, active-low.

Behaviour:
- Reset (i_rst_n=0 at a clock edge, at any state):
  - state = IDLE, gate = 0, outstanding = 0, timers = 0.
  - o_fifo_sel = ResetFifoSel, o_adapt_rst_n = 0, o_cfg_ack = 0, o_cfg_err = 0, o_cfg_busy = 0.
  - A request in progress is abandoned without an ack.
  - On the first cycle after reset release, o_adapt_rst_n goes to 1.
- Outstanding counter:
  - +1 on o_a_wb_stb & ~i_a_wb_stall.
  - −1 on i_a_wb_ack.
  - Both in the same cycle: counter unchanged.
  - Saturates at MaxOutstanding; an ack at 0 is ignored (no underflow).
  - Forced to 0 on entry to RESET.
- FSM states: IDLE, DRAIN, RESET, SETTLE, DONE. Let E0 be the edge at which the request is accepted.
- IDLE:
  - If i_cfg_req and i_cfg_fifo_sel ≠ o_fifo_sel: latch the new selection, go to DRAIN, gate = 1 from E0.
  - If i_cfg_req and i_cfg_fifo_sel = o_fifo_sel: go to DONE directly with err = 0; no gate, no reset.
- DRAIN:
  - Drain timer increments each cycle.
  - If outstanding = 0: go to RESET, err = 0.
  - Else if timer = DrainTimeout−1: go to RESET, err = 1.
  - On entering RESET: o_fifo_sel ← latched selection and o_adapt_rst_n ← 0 in the same edge.
- RESET: o_adapt_rst_n held low for exactly RstHoldCycles cycles, then go to SETTLE with o_adapt_rst_n ← 1.
- SETTLE: hold for exactly SettleCycles cycles, then go to DONE.
- DONE:
  - o_cfg_ack = 1 and o_cfg_err = err for this single cycle.
  - Next edge: go to IDLE and gate ← 0.
- Gate is 1 in DRAIN, RESET, SETTLE and DONE. It is never 1 in IDLE.
- Latency with nothing outstanding: ack asserted 1 + RstHoldCycles + SettleCycles cycles after E0 (9 with defaults).
- A master strobe held during gate sees stall and must hold; it is passed to the adapter after gate falls.
- i_cfg_req while busy is ignored. It is not queued, and a level request still high in IDLE after DONE starts a new evaluation.

Test Plan:
- Reset → o_fifo_sel = 0, o_adapt_rst_n = 0 during reset then 1, o_cfg_busy = 0, o_m_wb_stall tracks i_a_wb_stall.
- Idle switch 0→3 with no traffic, req at E0 → o_adapt_rst_n low E1..E4, o_fifo_sel = 3 from E1, o_cfg_ack = 1 and o_cfg_err = 0 in the cycle after E9, o_m_wb_stall = 1 throughout.
- Switch with 3 accepted and un-acked transactions; acks arrive 10, 12, 15 cycles after req → RESET entered the edge after the last ack, o_a_wb_stb = 0 during DRAIN despite i_m_wb_stb = 1, ack with err = 0.
- Same-cycle stb-accept and ack with outstanding = 2 → counter stays 2. Saturation: 5 accepts without acks → counter = 4. Spurious ack at 0 → counter stays 0.
- Drain timeout: 1 outstanding, never acked → RESET entered after 64 DRAIN cycles, counter cleared, ack with o_cfg_err = 1.
- Request for the current selection (2→2) → ack the cycle after acceptance, o_adapt_rst_n stays 1. i_rst_n = 0 mid-RESET → all outputs at reset values, no ack.
